// File: rtl/axil_reg_bank.sv
// axil_reg_bank: write-only register bank with CTRL/STATUS words and
// plain configuration registers, exposed as a flattened cfg_o bus.
// Word 0 is CTRL (START pulse, optional IE), word 1 is STATUS (DONE, W1C),
// words 2..NUM_REGS-1 are byte-strobed configuration registers.
// Optional feature: define AXIL_REG_BANK_IRQ_EN to build the IE bit and a
// registered level interrupt irq_o = DONE & IE; otherwise irq_o is tied low.
module axil_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 40,
  parameter int STRB_WIDTH = 4,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [ADDR_WIDTH-1:0]          reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]          reg_wr_data,
  input  logic [STRB_WIDTH-1:0]          reg_wr_strb,
  input  logic                           reg_wr_en,
  output logic                           reg_wr_wait,
  output logic                           reg_wr_ack,
  input  logic                           busy_i,
  input  logic                           done_i,
  output logic                           start_o,
  output logic                           irq_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_o
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [IDX_W-1:0]      idx;
  logic                  addr_ok;
  logic                  start_req;
  logic                  commit;
  logic                  hit_ctrl;
  logic                  hit_status;
  logic                  hit_cfg;
  logic                  ie_bit;

  logic                  ack_pend_q;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] cfg_q [NUM_REGS-2];
  logic [DATA_WIDTH-1:0] cfg_d [NUM_REGS-2];

  // Byte-offset bits never select anything; the name keeps lint quiet.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^reg_wr_addr[1:0];

  assign idx       = reg_wr_addr[IDX_W+1:2];
  assign addr_ok   = (reg_wr_addr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign start_req = reg_wr_strb[0] & reg_wr_data[0];

  // A START request stalls while the datapath runs; ack_pend blocks a held
  // request from being seen a second time in the ack cycle.
  assign reg_wr_wait = reg_wr_en & (idx == '0) & start_req & busy_i & ~ack_pend_q;
  assign commit      = reg_wr_en & ~reg_wr_wait & ~ack_pend_q;

  // Out-of-range writes commit (and are acked) but touch nothing.
  assign hit_ctrl   = commit & addr_ok & (idx == '0);
  assign hit_status = commit & addr_ok & (idx == IDX_W'(1));
  assign hit_cfg    = commit & addr_ok;

  assign reg_wr_ack = ack_pend_q;
  assign start_o    = start_q;

  // Next-state for START pulse and DONE (a new done_i beats a clear).
  always_comb begin
    start_d = hit_ctrl & start_req;
    done_d  = done_i | (done_q & ~(hit_status & reg_wr_strb[0] & reg_wr_data[0]));
  end

  // Byte-strobed update of the plain configuration registers.
  always_comb begin
    cfg_d = cfg_q;
    if (hit_cfg) begin
      for (int r = 2; r < NUM_REGS; r++) begin
        if (idx == IDX_W'(r)) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (reg_wr_strb[b]) cfg_d[r-2][b*8 +: 8] = reg_wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Handshake, pulse and register state; reset drops any pending ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_pend_q <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      for (int r = 0; r < NUM_REGS-2; r++) cfg_q[r] <= '0;
    end else begin
      ack_pend_q <= commit;
      start_q    <= start_d;
      done_q     <= done_d;
      cfg_q      <= cfg_d;
    end
  end

`ifdef AXIL_REG_BANK_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;

  // IE lives in CTRL bit1 and only moves when byte 0 is strobed.
  always_comb begin
    ie_d  = (hit_ctrl & reg_wr_strb[0]) ? reg_wr_data[1] : ie_q;
    irq_d = done_q & ie_q;
  end

  // Interrupt enable and registered level interrupt.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie_bit = ie_q;
  assign irq_o  = irq_q;
`else
  assign ie_bit = 1'b0;
  assign irq_o  = 1'b0;
`endif

  // Flatten the register image; unused CTRL/STATUS bits read as 0.
  always_comb begin
    cfg_o             = '0;
    cfg_o[1]          = ie_bit;
    cfg_o[DATA_WIDTH] = done_q;
    for (int r = 2; r < NUM_REGS; r++) begin
      cfg_o[r*DATA_WIDTH +: DATA_WIDTH] = cfg_q[r-2];
    end
  end

endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register and write-data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 40: write-address width in bits.
REQ-003 SHALL have parameter STRB_WIDTH, default 4: byte-strobe width; SHALL equal DATA_WIDTH/8.
REQ-004 SHALL have parameter NUM_REGS, default 8: number of registers; SHALL be a power of two and at least 4.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port reg_wr_addr, input, ADDR_WIDTH: byte address of the write.
REQ-008 SHALL have port reg_wr_data, input, DATA_WIDTH: write data.
REQ-009 SHALL have port reg_wr_strb, input, STRB_WIDTH: byte enables.
REQ-010 SHALL have port reg_wr_en, input, 1: write request; upstream holds it until it sees ack.
REQ-011 SHALL have port reg_wr_wait, output, 1: stall; while high, upstream freezes its timeout.
REQ-012 SHALL have port reg_wr_ack, output, 1: write-complete pulse.
REQ-013 SHALL have port busy_i, input, 1: the datapath is running.
REQ-014 SHALL have port done_i, input, 1: datapath-complete pulse.
REQ-015 SHALL have port start_o, output, 1: one-cycle start pulse.
REQ-016 SHALL have port irq_o, output, 1: level interrupt.
REQ-017 SHALL have port cfg_o, output, NUM_REGS*DATA_WIDTH: flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-018 SHALL decode the word index as idx = reg_wr_addr[$clog2(NUM_REGS)+1:2]; bits [1:0] are ignored.
- A write whose address bits above the index field are non-zero SHALL change nothing and SHALL still be acked.
REQ-019 SHALL implement this map:
- idx 0: CTRL. Bit0 = START, write-1 pulses start_o and is never stored. Bit1 = IE, stored (see REQ-027). Other bits read as 0.
- idx 1: STATUS. Bit0 = DONE, write-1-to-clear. Other bits read as 0.
- idx 2 to NUM_REGS-1: plain read/write configuration registers.
REQ-020 SHALL commit a write in the cycle where reg_wr_en=1, reg_wr_wait=0 and ack_pend=0.
- ack_pend is an internal flag set by the commit and cleared the following cycle.
REQ-021 SHALL update only the bytes whose reg_wr_strb bit is 1; START and DONE act only when strb[0]=1.
REQ-022 SHALL drive reg_wr_ack high for exactly one cycle, in the cycle after the commit; it is registered.
REQ-023 SHALL ignore reg_wr_en while reg_wr_ack=1, so a held request is never written twice.
REQ-024 SHALL assert reg_wr_wait combinationally when all of the following hold: reg_wr_en=1, idx=0, strb[0]=1, data[0]=1, busy_i=1, ack_pend=0.
- The write then commits in the first cycle busy_i=0.
REQ-025 SHALL pulse start_o high for one cycle, in the cycle after a committed START write.
REQ-026 SHALL set DONE on the cycle after done_i=1.
- If done_i and a clearing write occur in the same cycle, set SHALL win.
REQ-027 SHALL make cfg_o reflect committed writes one cycle after the commit.
- cfg_o word 0 = {0..., IE, 0}; word 1 = {0..., DONE}.

Reset
REQ-028 SHALL, while rstn=0, immediately force all of the following to 0, regardless of clk: every register, DONE, IE, ack_pend, reg_wr_ack, start_o and irq_o.
REQ-029 SHALL, when reset is asserted mid-transaction, drop the pending ack and any stalled write; no write commits after reset is released until reg_wr_en is seen again.

Configuration
REQ-030 SHALL, when macro AXIL_REG_BANK_IRQ_EN is defined:
- implement IE as CTRL bit1;
- drive irq_o = DONE & IE, registered.
REQ-031 SHALL, when AXIL_REG_BANK_IRQ_EN is undefined:
- keep the irq_o port present but tie it to 0;
- treat CTRL bit1 as read-as-0 and ignore writes to it;
- include no IE storage.

Verification
REQ-032 SHALL cover: write addr 0x8, data 0xDEADBEEF, strb 0xF, en held 2 cycles -> ack pulses 1 cycle at T+1; cfg word2=0xDEADBEEF; exactly one commit.
REQ-033 SHALL cover: word2=0xDEADBEEF, then write addr 0x8, data 0x00000011, strb 0x1 -> word2=0xDEADBE11.
REQ-034 SHALL cover: busy_i=1, then write addr 0x0, data 0x1 -> wait high, no ack, no start_o; drop busy_i at cycle 5 -> commit at 5, ack and start_o at 6.
REQ-035 SHALL cover: done_i pulse and write addr 0x4, data 0x1 in the same cycle -> DONE stays 1.
- Next lone clear -> DONE=0.
- With IRQ_EN defined and IE=1, irq_o follows DONE one cycle later.
REQ-036 SHALL cover: write addr 0x40 with NUM_REGS=8 -> ack pulses, all of cfg_o unchanged.
REQ-037 SHALL cover: rstn low for 1 cycle during a stalled START write -> wait, ack and start_o go to 0, cfg_o = 0, no start after release.
